// File: rtl/axis_velocity_estimator.sv
// axis_velocity_estimator: position delta over 2^L accepted samples, streamed as {seq, delta}.
// One result per window; results that cannot be loaded are dropped and flagged by a sticky overrun.
module axis_velocity_estimator #(
    parameter int S_AXIS_TDATA_WIDTH = 16,
    parameter int M_AXIS_TDATA_WIDTH = 32
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [4:0]                    log_decimation,
    input  logic                          clear_overrun,
    input  logic                          S_AXIS_tvalid,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                          S_AXIS_tready,
    input  logic                          M_AXIS_tready,
    output logic                          M_AXIS_tvalid,
    output logic [M_AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                          overrun
);
    typedef enum logic {PRIME, RUN} state_t;
    state_t state;
    logic [4:0] ld_q;
    logic [16:0] cnt, last;
    logic [15:0] ref_pos, delta, seq;
    logic accept;
    assign S_AXIS_tready = ~areset;
    assign accept = S_AXIS_tvalid & S_AXIS_tready;
    assign last = (17'd1 << (log_decimation > 5'd16 ? 5'd16 : log_decimation)) - 17'd1;
    // Modular subtraction keeps the signed delta correct across position wrap.
    assign delta = S_AXIS_tdata - ref_pos;
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= PRIME;
            ld_q <= '0;
            cnt <= '0;
            ref_pos <= '0;
            seq <= '0;
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tdata <= '0;
            overrun <= 1'b0;
        end else begin
            ld_q <= log_decimation;
            if (M_AXIS_tvalid && M_AXIS_tready) M_AXIS_tvalid <= 1'b0;
            if (clear_overrun) overrun <= 1'b0;
            // A window-length change restarts the window and discards the coincident sample.
            if (log_decimation != ld_q) begin
                state <= PRIME;
                cnt <= '0;
            end else if (accept) begin
                if (state == PRIME) begin
                    ref_pos <= S_AXIS_tdata;
                    cnt <= '0;
                    state <= RUN;
                end else if (cnt == last) begin
                    ref_pos <= S_AXIS_tdata;
                    cnt <= '0;
                    seq <= seq + 16'd1;
                    if (!M_AXIS_tvalid || M_AXIS_tready) begin
                        M_AXIS_tdata <= {seq, delta};
                        M_AXIS_tvalid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 17'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_axis_velocity_estimator.sv
// tb_axis_velocity_estimator: table vectors, directed corner sequences and random traffic
// checked against a queue-based window model of the velocity estimator.
module tb_axis_velocity_estimator;
    logic aclk = 1'b0, areset = 1'b1;
    logic [4:0] log_decimation = 5'd2;
    logic clear_overrun = 1'b0, S_AXIS_tvalid = 1'b0, M_AXIS_tready = 1'b0;
    logic [15:0] S_AXIS_tdata = '0;
    logic S_AXIS_tready, M_AXIS_tvalid, overrun;
    logic [31:0] M_AXIS_tdata;
    int checks = 0, errors = 0;

    axis_velocity_estimator dut (
        .aclk(aclk), .areset(areset), .log_decimation(log_decimation),
        .clear_overrun(clear_overrun), .S_AXIS_tvalid(S_AXIS_tvalid),
        .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tready(S_AXIS_tready),
        .M_AXIS_tready(M_AXIS_tready), .M_AXIS_tvalid(M_AXIS_tvalid),
        .M_AXIS_tdata(M_AXIS_tdata), .overrun(overrun)
    );

    always #5 aclk = ~aclk;

    // Reference model: keeps the window's samples in a queue and emits when it spans N+1 samples.
    logic m_valid, m_ovr, m_prime, nv, no;
    logic [31:0] m_data;
    logic [15:0] m_seq, m_delta;
    logic [4:0] m_ldq;
    logic [15:0] win[$];
    int n;
    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_valid = 0; m_ovr = 0; m_data = 0; m_seq = 0; m_ldq = 0; m_prime = 1;
            win.delete();
        end else begin
            nv = m_valid && !M_AXIS_tready;
            no = m_ovr && !clear_overrun;
            n = 1 << ((log_decimation > 16) ? 16 : int'(log_decimation));
            if (log_decimation != m_ldq) begin
                m_prime = 1;
                win.delete();
            end else if (S_AXIS_tvalid) begin
                if (m_prime) begin
                    win.delete();
                    m_prime = 0;
                end
                win.push_back(S_AXIS_tdata);
                if (win.size() == n + 1) begin
                    m_delta = win[n] - win[0];
                    win.delete();
                    win.push_back(S_AXIS_tdata);
                    if (!m_valid || M_AXIS_tready) begin
                        m_data = {m_seq, m_delta};
                        nv = 1;
                    end else no = 1;
                    m_seq = m_seq + 1;
                end
            end
            m_valid = nv; m_ovr = no; m_ldq = log_decimation;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("model_tvalid", 32'(M_AXIS_tvalid), 32'(m_valid));
        chk("model_tdata", M_AXIS_tdata, m_data);
        chk("model_overrun", 32'(overrun), 32'(m_ovr));
        chk("model_s_tready", 32'(S_AXIS_tready), 32'(!areset));
    endtask

    task automatic step(input logic tv, input logic [15:0] td, input logic tr, input logic clr);
        S_AXIS_tvalid = tv; S_AXIS_tdata = td; M_AXIS_tready = tr; clear_overrun = clr;
        @(negedge aclk);
        cmp_model();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
    endtask

    typedef struct {
        logic tv; logic [15:0] td; logic tr;
        logic ev; logic [31:0] ed; logic eo;
    } vec_t;
    vec_t tbl[11];

    initial begin
        tbl[0]  = '{0, 16'd0, 1, 0, 32'h0, 0};
        tbl[1]  = '{1, 16'd0, 1, 0, 32'h0, 0};
        tbl[2]  = '{1, 16'd1, 1, 0, 32'h0, 0};
        tbl[3]  = '{1, 16'd2, 1, 0, 32'h0, 0};
        tbl[4]  = '{1, 16'd3, 1, 0, 32'h0, 0};
        tbl[5]  = '{1, 16'd4, 1, 1, 32'h00000004, 0};
        tbl[6]  = '{1, 16'd5, 1, 0, 32'h00000004, 0};
        tbl[7]  = '{1, 16'd6, 1, 0, 32'h00000004, 0};
        tbl[8]  = '{1, 16'd7, 1, 0, 32'h00000004, 0};
        tbl[9]  = '{1, 16'd8, 1, 1, 32'h00010004, 0};
        tbl[10] = '{0, 16'd0, 1, 0, 32'h00010004, 0};
        @(negedge aclk);
        @(negedge aclk);
        chk("reset_tvalid", 32'(M_AXIS_tvalid), 0);
        chk("reset_tdata", M_AXIS_tdata, 0);
        chk("reset_overrun", 32'(overrun), 0);
        chk("reset_s_tready", 32'(S_AXIS_tready), 0);
        areset = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].tv, tbl[i].td, tbl[i].tr, 0);
            chk($sformatf("tbl%0d_tvalid", i), 32'(M_AXIS_tvalid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_tdata", i), M_AXIS_tdata, tbl[i].ed);
            chk($sformatf("tbl%0d_overrun", i), 32'(overrun), 32'(tbl[i].eo));
        end
        // L = 0 across position wrap in both directions
        log_decimation = 5'd0;
        step(0, 0, 1, 0);
        step(1, 16'h7FF0, 1, 0);
        chk("wrap_prime_tvalid", 32'(M_AXIS_tvalid), 0);
        step(1, 16'h8010, 1, 0);
        chk("wrap_up", M_AXIS_tdata, 32'h00020020);
        chk("wrap_up_tvalid", 32'(M_AXIS_tvalid), 1);
        step(1, 16'h7FF0, 1, 0);
        chk("wrap_down", M_AXIS_tdata, 32'h0003FFE0);
        chk("wrap_down_tvalid", 32'(M_AXIS_tvalid), 1);
        // back-pressure, drop, clear coinciding with drop, later clear
        log_decimation = 5'd1;
        do_reset();
        step(0, 0, 0, 0);
        for (int k = 0; k <= 3; k++) step(1, 16'(k), 0, 0);
        chk("hold_tdata", M_AXIS_tdata, 32'h00000002);
        chk("hold_overrun", 32'(overrun), 0);
        step(1, 16'd4, 0, 1);
        chk("drop_tdata", M_AXIS_tdata, 32'h00000002);
        chk("drop_tvalid", 32'(M_AXIS_tvalid), 1);
        chk("drop_set_wins", 32'(overrun), 1);
        step(0, 0, 1, 0);
        chk("xfer_tvalid", 32'(M_AXIS_tvalid), 0);
        chk("xfer_overrun", 32'(overrun), 1);
        step(0, 0, 1, 1);
        chk("clear_overrun", 32'(overrun), 0);
        step(1, 16'd5, 1, 0);
        step(1, 16'd6, 1, 0);
        chk("seq_gap", M_AXIS_tdata, 32'h00020002);
        // mid-window change of log_decimation discards the coincident sample
        log_decimation = 5'd3;
        step(0, 0, 1, 0);
        for (int k = 20; k <= 23; k++) step(1, 16'(k), 1, 0);
        log_decimation = 5'd1;
        step(1, 16'd99, 1, 0);
        chk("restart_no_out", 32'(M_AXIS_tvalid), 0);
        step(1, 16'd30, 1, 0);
        chk("restart_prime", 32'(M_AXIS_tvalid), 0);
        step(1, 16'd31, 1, 0);
        step(1, 16'd32, 1, 0);
        chk("restart_out1", M_AXIS_tdata, 32'h00030002);
        step(1, 16'd33, 1, 0);
        step(1, 16'd34, 1, 0);
        chk("restart_out2", M_AXIS_tdata, 32'h00040002);
        step(1, 16'd35, 0, 0);
        step(1, 16'd36, 0, 0);
        chk("pre_reset_overrun", 32'(overrun), 1);
        chk("pre_reset_tvalid", 32'(M_AXIS_tvalid), 1);
        // asynchronous reset away from any clock edge
        #2 areset = 1'b1;
        #1;
        chk("async_tvalid", 32'(M_AXIS_tvalid), 0);
        chk("async_tdata", M_AXIS_tdata, 0);
        chk("async_overrun", 32'(overrun), 0);
        chk("async_s_tready", 32'(S_AXIS_tready), 0);
        @(negedge aclk);
        cmp_model();
        areset = 1'b0;
        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 31) == 0) log_decimation = 5'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
